// File: rtl/mcp3202_spi_responder.sv
// MCP3202 12-bit ADC responder for a mode 0,0 SPI bus.
// Oversamples SCK/CS/MOSI in the clk domain and shifts back a latched result.
module mcp3202_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] i_CH0_DATA,
    input  logic [11:0] i_CH1_DATA,
    output logic [2:0]  o_CFG,
    output logic        o_CFG_VALID,
    output logic        o_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_CMD,
        S_NULL,
        S_DATA_MSB,
        S_DATA_LSB,
        S_TAIL
    } state_t;

    // Depth outside 2..3 is not supported.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("SYNC_STAGES must be 2 or 3");
    end

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic w_sck;
    logic w_cs;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_cmd;
    logic [11:0] r_result;
    logic        r_miso;
    logic        r_oe;
    logic [2:0]  r_cfg;
    logic        r_cfg_valid;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [2:0]  w_cmd_nxt;
    logic [11:0] w_result_nxt;
    logic        w_miso_nxt;
    logic        w_oe_nxt;
    logic [2:0]  w_cfg_nxt;
    logic        w_cfg_valid_nxt;
    logic        w_busy_nxt;

    logic [12:0] w_d01;
    logic [12:0] w_d10;
    logic [11:0] w_sel;

    // Synchronizers cleared to 0 so a CS held low across reset
    // produces no falling edge: the master must cycle CS first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_cs_rise  = w_cs & ~r_cs_d;
    assign w_cs_fall  = ~w_cs & r_cs_d;

    assign w_d01 = {1'b0, i_CH0_DATA} - {1'b0, i_CH1_DATA};
    assign w_d10 = {1'b0, i_CH1_DATA} - {1'b0, i_CH0_DATA};

    // Result selection from {SGL, ODD}; differences clamp at zero.
    always_comb begin
        w_sel = i_CH0_DATA;
        case (r_cmd[1:0])
            2'b10:   w_sel = i_CH0_DATA;
            2'b11:   w_sel = i_CH1_DATA;
            2'b00:   w_sel = w_d01[12] ? 12'd0 : w_d01[11:0];
            default: w_sel = w_d10[12] ? 12'd0 : w_d10[11:0];
        endcase
    end

    // Frame sequencing; CS deassert overrides any SCK edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cmd_nxt       = r_cmd;
        w_result_nxt    = r_result;
        w_miso_nxt      = r_miso;
        w_oe_nxt        = r_oe;
        w_cfg_nxt       = r_cfg;
        w_cfg_valid_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_miso_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt = S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (w_sck_rise && w_mosi) begin
                        w_state_nxt = S_CMD;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_CMD: begin
                    if (w_sck_rise) begin
                        w_cmd_nxt = {r_cmd[1:0], w_mosi};
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == 4'd2) begin
                            w_result_nxt    = w_sel;
                            w_cfg_nxt       = {r_cmd[1:0], w_mosi};
                            w_cfg_valid_nxt = 1'b1;
                            w_state_nxt     = S_NULL;
                        end
                    end
                end
                S_NULL: begin
                    if (w_sck_fall) begin
                        w_miso_nxt  = 1'b0;
                        w_oe_nxt    = 1'b1;
                        w_cnt_nxt   = 4'd11;
                        w_state_nxt = S_DATA_MSB;
                    end
                end
                S_DATA_MSB: begin
                    if (w_sck_fall) begin
                        w_miso_nxt = r_result[r_cnt];
                        if (r_cnt == 4'd0) begin
                            w_cnt_nxt   = 4'd1;
                            w_state_nxt = r_cmd[0] ? S_TAIL : S_DATA_LSB;
                        end else begin
                            w_cnt_nxt = r_cnt - 4'd1;
                        end
                    end
                end
                S_DATA_LSB: begin
                    if (w_sck_fall) begin
                        w_miso_nxt = r_result[r_cnt];
                        if (r_cnt == 4'd11) begin
                            w_state_nxt = S_TAIL;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end
                S_TAIL: begin
                    if (w_sck_fall) begin
                        w_miso_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Frame state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cmd       <= 3'd0;
            r_result    <= 12'd0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_cfg       <= 3'd0;
            r_cfg_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_result    <= w_result_nxt;
            r_miso      <= w_miso_nxt;
            r_oe        <= w_oe_nxt;
            r_cfg       <= w_cfg_nxt;
            r_cfg_valid <= w_cfg_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign MISO        = r_oe ? r_miso : 1'bz;
    assign o_CFG       = r_cfg;
    assign o_CFG_VALID = r_cfg_valid;
    assign o_BUSY      = r_busy;

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Directed bench for mcp3202_spi_responder.
// Two instances share inputs; one MISO net is pulled up, the other down, so hi-z is visible.
module tb_mcp3202_spi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCK = 1'b0;
    logic        CS = 1'b1;
    logic        MOSI = 1'b0;
    logic [11:0] i_CH0_DATA = 12'd0;
    logic [11:0] i_CH1_DATA = 12'd0;

    wire         w_miso_pu;
    wire         w_miso_pd;
    logic [2:0]  o_CFG;
    logic        o_CFG_VALID;
    logic        o_BUSY;
    logic [2:0]  b_cfg;
    logic        b_cfg_valid;
    logic        b_busy;

    pullup   (w_miso_pu);
    pulldown (w_miso_pd);

    mcp3202_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI),
        .MISO(w_miso_pu),
        .i_CH0_DATA(i_CH0_DATA), .i_CH1_DATA(i_CH1_DATA),
        .o_CFG(o_CFG), .o_CFG_VALID(o_CFG_VALID), .o_BUSY(o_BUSY)
    );

    mcp3202_spi_responder #(.SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI),
        .MISO(w_miso_pd),
        .i_CH0_DATA(i_CH0_DATA), .i_CH1_DATA(i_CH1_DATA),
        .o_CFG(b_cfg), .o_CFG_VALID(b_cfg_valid), .o_BUSY(b_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt = 0;
    logic [63:0] rx_val;
    logic [63:0] rx_oe;
    logic        busy_seen;

    always @(posedge clk) begin
        if (o_CFG_VALID) vcnt <= vcnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic driven();
        return w_miso_pu == w_miso_pd;
    endfunction

    // One SPI frame: MISO is sampled just before every SCK rise.
    task automatic spi_frame(input logic [31:0] mosi, input int nmosi,
                             input int nclk, input int chg_at,
                             input logic [11:0] chg_val, input bit keep_cs);
        rx_val = '0;
        rx_oe  = '0;
        @(negedge clk) CS = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            MOSI = (i < nmosi) ? mosi[nmosi-1-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            rx_val    = {rx_val[62:0], w_miso_pd};
            rx_oe     = {rx_oe[62:0], driven()};
            busy_seen = o_BUSY;
            if (i == chg_at) i_CH0_DATA = chg_val;
            SCK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (!keep_cs) begin
            CS = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    int v0;

    initial begin
        // reset with CS low and SCK toggling
        repeat (3) @(negedge clk);
        CS = 1'b0;
        MOSI = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk) SCK = ~SCK;
        end
        check("rst_oe", 64'(driven()), 64'd0);
        check("rst_busy", 64'(o_BUSY), 64'd0);
        check("rst_cfg", 64'(o_CFG), 64'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            repeat (HALF) @(negedge clk) SCK = ~SCK;
        end
        SCK = 1'b0;
        repeat (HALF) @(negedge clk);
        check("norsp_oe", 64'(driven()), 64'd0);
        check("norsp_busy", 64'(o_BUSY), 64'd0);
        check("norsp_vcnt", 64'(vcnt), 64'd0);
        CS = 1'b1;
        MOSI = 1'b0;
        repeat (6) @(negedge clk);

        // CH0 single-ended, MSB first
        i_CH0_DATA = 12'hD73;
        i_CH1_DATA = 12'h2B4;
        v0 = vcnt;
        spi_frame(32'b1101, 4, 24, -1, 12'h0, 1'b1);
        check("ch0_busy", 64'(busy_seen), 64'd1);
        CS = 1'b1;
        repeat (6) @(negedge clk);
        check("ch0_val", rx_val, 64'({5'b0, 12'hD73, 7'b0}));
        check("ch0_oe", rx_oe, 64'({4'b0, 20'hFFFFF}));
        check("ch0_cfg", 64'(o_CFG), 64'b101);
        check("ch0_vpulse", 64'(vcnt - v0), 64'd1);
        check("ch0_z_after", 64'(driven()), 64'd0);
        check("ch0_busy_after", 64'(o_BUSY), 64'd0);

        // CH1 with LSB-first tail
        i_CH1_DATA = 12'h003;
        spi_frame(32'b1110, 4, 32, -1, 12'h0, 1'b0);
        check("ch1_val", rx_val,
              64'({5'b0, 12'h003, 11'b10000000000, 4'b0}));
        check("ch1_oe", rx_oe, 64'({4'b0, 28'hFFFFFFF}));
        check("ch1_cfg", 64'(o_CFG), 64'b110);

        // differential CH0-CH1
        i_CH0_DATA = 12'h100;
        i_CH1_DATA = 12'h040;
        spi_frame(32'b1001, 4, 24, -1, 12'h0, 1'b0);
        check("dif01_val", rx_val, 64'({5'b0, 12'h0C0, 7'b0}));
        check("dif01_cfg", 64'(o_CFG), 64'b001);

        // differential CH1-CH0, clamped
        spi_frame(32'b1011, 4, 24, -1, 12'h0, 1'b0);
        check("dif10_val", rx_val, 64'd0);
        check("dif10_oe", rx_oe, 64'({4'b0, 20'hFFFFF}));
        check("dif10_cfg", 64'(o_CFG), 64'b011);

        // partial command leaves o_CFG alone
        v0 = vcnt;
        spi_frame(32'b110, 3, 3, -1, 12'h0, 1'b0);
        check("part_cfg", 64'(o_CFG), 64'b011);
        check("part_vpulse", 64'(vcnt - v0), 64'd0);
        check("part_z", 64'(driven()), 64'd0);

        // leading zeros before the start bit
        i_CH0_DATA = 12'hA5C;
        spi_frame(32'b001101, 6, 26, -1, 12'h0, 1'b0);
        check("lead_val", rx_val, 64'({7'b0, 12'hA5C, 7'b0}));
        check("lead_oe", rx_oe, 64'({6'b0, 20'hFFFFF}));
        check("lead_cfg", 64'(o_CFG), 64'b101);

        // abort after B7
        i_CH0_DATA = 12'hD73;
        spi_frame(32'b1101, 4, 10, -1, 12'h0, 1'b1);
        check("abort_val", rx_val, 64'({5'b0, 5'b11010}));
        check("abort_oe", rx_oe, 64'({4'b0, 6'b111111}));
        @(negedge clk) CS = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_z", 64'(driven()), 64'd0);
        check("abort_busy", 64'(o_BUSY), 64'd0);
        repeat (6) @(negedge clk);
        spi_frame(32'b1101, 4, 24, -1, 12'h0, 1'b0);
        check("reframe_val", rx_val, 64'({5'b0, 12'hD73, 7'b0}));
        check("reframe_oe", rx_oe, 64'({4'b0, 20'hFFFFF}));

        // CH0 changes mid-DATA_MSB; latched word is shifted
        i_CH0_DATA = 12'h5A3;
        spi_frame(32'b1101, 4, 24, 8, 12'hFFF, 1'b0);
        check("latch_val", rx_val, 64'({5'b0, 12'h5A3, 7'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
